// File: rtl/rf_write_arbiter.sv
// Two-source writeback arbiter for the register file's single write port.
// Each source queues (addr, data) in a small FIFO; a round-robin picker drains one entry per cycle.

module rf_wb_fifo #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int DEPTH     = 2,
  parameter int DROP_ZERO = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_addr,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     pop,
  output logic                     empty,
  output logic [ADDR_W-1:0]        head_addr,
  output logic [DATA_W-1:0]        head_data,
  output logic [(1<<ADDR_W)-1:0]   pend_mask
);
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]       count_q, count_d;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic              push;

  // Ready looks only at occupancy, so a full FIFO stays closed even on a pop cycle.
  assign in_ready  = count_q < (PW+1)'(DEPTH);
  assign empty     = (count_q == '0);
  assign push      = in_valid && in_ready && !((DROP_ZERO != 0) && (in_addr == '0));
  assign head_addr = addr_q[rd_ptr_q];
  assign head_data = data_q[rd_ptr_q];

  always_comb begin
    addr_d   = addr_q;
    data_d   = data_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      addr_d[wr_ptr_q] = in_addr;
      data_d[wr_ptr_q] = in_data;
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop)      count_d = count_q + (PW+1)'(1);
    else if (!push && pop) count_d = count_q - (PW+1)'(1);
  end

  // Slot i is live when its distance from the read pointer is below the count.
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ({1'b0, PW'(PW'(i) - rd_ptr_q)} < count_q) pend_mask[addr_q[i]] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      addr_q   <= '{default: '0};
      data_q   <= '{default: '0};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end
endmodule

module rf_write_arbiter #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int DEPTH     = 2,
  parameter int DROP_ZERO = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   a_valid,
  output logic                   a_ready,
  input  logic [ADDR_W-1:0]      a_addr,
  input  logic [DATA_W-1:0]      a_data,
  input  logic                   b_valid,
  output logic                   b_ready,
  input  logic [ADDR_W-1:0]      b_addr,
  input  logic [DATA_W-1:0]      b_data,
  output logic                   reg_write,
  output logic [ADDR_W-1:0]      write_address,
  output logic [DATA_W-1:0]      write,
  output logic [(1<<ADDR_W)-1:0] pending,
  output logic                   idle
);
  localparam int NSRC = 2;
  localparam int NREG = 1 << ADDR_W;

  typedef enum logic {ST_IDLE, ST_ISSUE} state_e;

  logic [NSRC-1:0]             src_valid, src_ready, src_empty, pop;
  logic [NSRC-1:0][ADDR_W-1:0] src_addr, head_addr;
  logic [NSRC-1:0][DATA_W-1:0] src_data, head_data;
  logic [NSRC-1:0][NREG-1:0]   src_pend;

  state_e            state_q, state_d;
  logic              prio_b_q, prio_b_d;
  logic [ADDR_W-1:0] write_address_q, write_address_d;
  logic [DATA_W-1:0] write_q, write_d;
  logic              any_req, grant_b;

  assign src_valid = {b_valid, a_valid};
  assign src_addr  = {b_addr, a_addr};
  assign src_data  = {b_data, a_data};
  assign a_ready   = src_ready[0];
  assign b_ready   = src_ready[1];

  genvar g;
  generate
    for (g = 0; g < NSRC; g++) begin : g_src
      rf_wb_fifo #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .DROP_ZERO(DROP_ZERO)
      ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (src_valid[g]),
        .in_ready  (src_ready[g]),
        .in_addr   (src_addr[g]),
        .in_data   (src_data[g]),
        .pop       (pop[g]),
        .empty     (src_empty[g]),
        .head_addr (head_addr[g]),
        .head_data (head_data[g]),
        .pend_mask (src_pend[g])
      );
    end
  endgenerate

  // prio_b_q set means A was granted last, so B wins the next contended cycle.
  always_comb begin
    any_req         = ~&src_empty;
    grant_b         = !src_empty[1] && (src_empty[0] || prio_b_q);
    pop             = '0;
    state_d         = ST_IDLE;
    prio_b_d        = prio_b_q;
    write_address_d = write_address_q;
    write_d         = write_q;
    if (any_req) begin
      pop             = grant_b ? 2'b10 : 2'b01;
      state_d         = ST_ISSUE;
      prio_b_d        = !grant_b;
      write_address_d = head_addr[grant_b];
      write_d         = head_data[grant_b];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      prio_b_q        <= 1'b0;
      write_address_q <= '0;
      write_q         <= '0;
    end else begin
      state_q         <= state_d;
      prio_b_q        <= prio_b_d;
      write_address_q <= write_address_d;
      write_q         <= write_d;
    end
  end

  assign reg_write     = (state_q == ST_ISSUE);
  assign write_address = write_address_q;
  assign write         = write_q;
  assign idle          = (&src_empty) && !reg_write;

  always_comb begin
    pending = '0;
    for (int s = 0; s < NSRC; s++) pending = pending | src_pend[s];
    if (reg_write) pending[write_address_q] = 1'b1;
  end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: reset, single write, contention, full FIFO, r0 drop, same-address race.
module tb_rf_write_arbiter;
  logic        clk, rst_n;
  logic        a_valid, b_valid, a_ready, b_ready;
  logic [4:0]  a_addr, b_addr, write_address;
  logic [31:0] a_data, b_data, write, pending;
  logic        reg_write, idle;

  int passed = 0, total = 0;
  logic [4:0]  iss_addr[$];
  logic [31:0] iss_data[$];
  logic [31:0] rf [32];
  logic        rdy_a_log [64];
  logic        rdy_b_log [64];
  int          b_acc_edge [8];

  rf_write_arbiter #(.DATA_W(32), .ADDR_W(5), .DEPTH(2), .DROP_ZERO(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .reg_write(reg_write), .write_address(write_address), .write(write),
    .pending(pending), .idle(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Regfile model and issue log, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n && reg_write) begin
      iss_addr.push_back(write_address);
      iss_data.push_back(write);
      rf[write_address] = write;
    end
  end

  task automatic apply_reset();
    rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    a_addr = '0; b_addr = '0; a_data = '0; b_data = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    iss_addr.delete(); iss_data.delete();
  endtask

  task automatic drive_streams(input int na, input int nb, input logic [4:0] ab, input logic [4:0] bb);
    int ai = 0, bi = 0, e = 0;
    logic fa, fb;
    while ((ai < na || bi < nb) && e < 60) begin
      a_valid = (ai < na); a_addr = ab + 5'(ai); a_data = 32'hA000_0000 | 32'(a_addr);
      b_valid = (bi < nb); b_addr = bb + 5'(bi); b_data = 32'hB000_0000 | 32'(b_addr);
      rdy_a_log[e] = a_ready; rdy_b_log[e] = b_ready;
      fa = a_valid && a_ready; fb = b_valid && b_ready;
      @(posedge clk); #1; e++;
      if (fa) ai++;
      if (fb) begin b_acc_edge[bi] = e; bi++; end
    end
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (idle) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (idle !== 1'b1 || pending !== 32'h0 || reg_write !== 1'b0) $display("FAIL reset_state: idle=%b pending=%h rw=%b want 1/0/0", idle, pending, reg_write); else passed++;
    a_valid = 1; a_addr = 3; a_data = 32'h33; b_valid = 1; b_addr = 4; b_data = 32'h44;
    @(posedge clk); #1;
    a_addr = 5; a_data = 32'h55; b_addr = 6; b_data = 32'h66;
    @(posedge clk); #1;
    a_valid = 0; b_valid = 0;
    total++; if (reg_write !== 1'b1 || b_ready !== 1'b0) $display("FAIL reset_prefill: rw=%b b_ready=%b want 1/0", reg_write, b_ready); else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++; if (reg_write !== 1'b0) $display("FAIL reset_async_rw: got %b want 0", reg_write); else passed++;
    total++; if (pending !== 32'h0) $display("FAIL reset_pending: got %h want 0", pending); else passed++;
    @(posedge clk); #2 rst_n = 1'b1; #1;
    total++; if (a_ready !== 1'b1 || b_ready !== 1'b1 || idle !== 1'b1) $display("FAIL reset_release: a_rdy=%b b_rdy=%b idle=%b want 1/1/1", a_ready, b_ready, idle); else passed++;
    @(posedge clk); #1;
    total++; if (reg_write !== 1'b0 || pending !== 32'h0) $display("FAIL reset_lost: rw=%b pending=%h want 0/0", reg_write, pending); else passed++;
  endtask

  task automatic test_single();
    apply_reset();
    a_valid = 1; a_addr = 5; a_data = 32'hDEADBEEF;
    total++; if (a_ready !== 1'b1 || reg_write !== 1'b0) $display("FAIL single_pre: a_rdy=%b rw=%b want 1/0", a_ready, reg_write); else passed++;
    @(posedge clk); #1; a_valid = 0;
    total++; if (pending !== 32'h20 || reg_write !== 1'b0 || idle !== 1'b0) $display("FAIL single_e1: pending=%h rw=%b idle=%b want 20/0/0", pending, reg_write, idle); else passed++;
    @(posedge clk); #1;
    total++; if (reg_write !== 1'b1 || write_address !== 5'd5 || write !== 32'hDEADBEEF) $display("FAIL single_e2: rw=%b wa=%0d wd=%h want 1/5/deadbeef", reg_write, write_address, write); else passed++;
    total++; if (pending !== 32'h20) $display("FAIL single_pend_e2: got %h want 20", pending); else passed++;
    @(posedge clk); #1;
    total++; if (reg_write !== 1'b0 || pending !== 32'h0 || idle !== 1'b1) $display("FAIL single_e3: rw=%b pending=%h idle=%b want 0/0/1", reg_write, pending, idle); else passed++;
    total++; if (write !== 32'hDEADBEEF || write_address !== 5'd5) $display("FAIL single_hold: wa=%0d wd=%h want 5/deadbeef", write_address, write); else passed++;
  endtask

  task automatic test_contention();
    bit ok;
    logic [4:0] ea;
    apply_reset();
    drive_streams(6, 6, 5'd1, 5'd11);
    wait_idle(ok);
    total++; if (!ok) $display("FAIL contention_timeout: idle never rose"); else passed++;
    total++; if (rdy_a_log[2] !== 1'b1 || rdy_b_log[2] !== 1'b0) $display("FAIL contention_ready_e2: a=%b b=%b want 1/0", rdy_a_log[2], rdy_b_log[2]); else passed++;
    total++; if (rdy_a_log[3] !== 1'b0 || rdy_b_log[3] !== 1'b1) $display("FAIL contention_ready_e3: a=%b b=%b want 0/1", rdy_a_log[3], rdy_b_log[3]); else passed++;
    total++; if (iss_addr.size() != 12) $display("FAIL contention_count: got %0d want 12", iss_addr.size()); else passed++;
    for (int k = 0; k < 12 && k < iss_addr.size(); k++) begin
      ea = (k % 2 == 0) ? 5'(1 + k/2) : 5'(11 + k/2);
      total++; if (iss_addr[k] !== ea || iss_data[k] !== (((k % 2 == 0) ? 32'hA000_0000 : 32'hB000_0000) | 32'(ea)))
        $display("FAIL contention_issue%0d: got %0d/%h want %0d", k, iss_addr[k], iss_data[k], ea); else passed++;
    end
  endtask

  task automatic test_full();
    bit ok;
    logic [4:0] exp_a [7];
    exp_a = '{5'd21, 5'd25, 5'd22, 5'd26, 5'd23, 5'd27, 5'd24};
    apply_reset();
    drive_streams(4, 3, 5'd21, 5'd25);
    wait_idle(ok);
    total++; if (!ok) $display("FAIL full_timeout: idle never rose"); else passed++;
    total++; if (rdy_b_log[2] !== 1'b0) $display("FAIL full_b_ready: got %b want 0", rdy_b_log[2]); else passed++;
    total++; if (b_acc_edge[0] != 1 || b_acc_edge[1] != 2 || b_acc_edge[2] != 4) $display("FAIL full_b_accept: edges %0d,%0d,%0d want 1,2,4", b_acc_edge[0], b_acc_edge[1], b_acc_edge[2]); else passed++;
    total++; if (iss_addr.size() != 7) $display("FAIL full_count: got %0d want 7", iss_addr.size()); else passed++;
    for (int k = 0; k < 7 && k < iss_addr.size(); k++) begin
      total++; if (iss_addr[k] !== exp_a[k]) $display("FAIL full_issue%0d: got %0d want %0d", k, iss_addr[k], exp_a[k]); else passed++;
    end
  endtask

  task automatic test_drop_zero();
    apply_reset();
    a_valid = 1; a_addr = 0; a_data = 32'h1234;
    total++; if (a_ready !== 1'b1) $display("FAIL zero_ready: got %b want 1", a_ready); else passed++;
    @(posedge clk); #1; a_valid = 0;
    total++; if (pending !== 32'h0 || idle !== 1'b1 || a_ready !== 1'b1) $display("FAIL zero_e1: pending=%h idle=%b a_rdy=%b want 0/1/1", pending, idle, a_ready); else passed++;
    repeat (3) begin @(posedge clk); #1; end
    total++; if (iss_addr.size() != 0 || reg_write !== 1'b0 || pending !== 32'h0) $display("FAIL zero_issue: issued=%0d rw=%b pending=%h want 0/0/0", iss_addr.size(), reg_write, pending); else passed++;
  endtask

  task automatic test_same_addr();
    bit ok;
    apply_reset();
    rf[7] = 32'h0;
    a_valid = 1; a_addr = 7; a_data = 32'hAA; b_valid = 1; b_addr = 7; b_data = 32'hBB;
    @(posedge clk); #1; a_valid = 0; b_valid = 0;
    total++; if (pending !== 32'h80) $display("FAIL race_pending: got %h want 80", pending); else passed++;
    wait_idle(ok);
    @(posedge clk); #1;
    total++; if (!ok || iss_addr.size() != 2) $display("FAIL race_count: ok=%b issued=%0d want 1/2", ok, iss_addr.size()); else passed++;
    total++; if (iss_addr.size() == 2 && (iss_data[0] !== 32'hAA || iss_data[1] !== 32'hBB)) $display("FAIL race_order: got %h,%h want aa,bb", iss_data[0], iss_data[1]); else passed++;
    total++; if (rf[7] !== 32'hBB) $display("FAIL race_final: got %h want bb", rf[7]); else passed++;
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 32; i++) rf[i] = '0;
    test_reset();
    test_single();
    test_contention();
    test_full();
    test_drop_zero();
    test_same_addr();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
